// File: rtl/switch_toggle_bank.sv
// switch_toggle_bank: per-channel two-flop synchroniser, counter debounce and edge
// qualifier; each qualified edge toggles the channel LED and bumps its press counter.
module switch_toggle_bank #(
    parameter int NUM_SWITCHES   = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int EDGE_MODE      = 0,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                                i_Clk,
    input  logic                                i_Reset,
    input  logic [NUM_SWITCHES-1:0]             i_Switch,
    input  logic                                i_Clear,
    output logic [NUM_SWITCHES-1:0]             o_Switch_Clean,
    output logic [NUM_SWITCHES-1:0]             o_Edge_Pulse,
    output logic [NUM_SWITCHES-1:0]             o_LED,
    output logic [NUM_SWITCHES*COUNT_WIDTH-1:0] o_Press_Count
);

    localparam int              DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_LIMIT - 1);
    // Mode 0 counts releases only, mode 1 presses only, anything else both.
    localparam bit USE_RISE = (EDGE_MODE != 0);
    localparam bit USE_FALL = (EDGE_MODE != 1);

    for (genvar n = 0; n < NUM_SWITCHES; n++) begin : g_ch
        logic                   sync1_q;
        logic                   sync2_q;
        logic [DB_W-1:0]        db_cnt_q;
        logic [DB_W-1:0]        db_cnt_d;
        logic                   clean_q;
        logic                   clean_d;
        logic                   prev_q;
        logic                   rise;
        logic                   fall;
        logic                   pulse_q;
        logic                   pulse_d;
        logic                   led_q;
        logic                   led_d;
        logic [COUNT_WIDTH-1:0] press_q;
        logic [COUNT_WIDTH-1:0] press_d;

        // A sample agreeing with the accepted level restarts the stability count.
        always_comb begin
            db_cnt_d = db_cnt_q;
            clean_d  = clean_q;
            if (sync2_q == clean_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_TERM) begin
                clean_d  = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        assign rise    = clean_q & ~prev_q;
        assign fall    = ~clean_q & prev_q;
        assign pulse_d = (USE_RISE & rise) | (USE_FALL & fall);

        // Clear wins over a coincident pulse, so that edge is dropped.
        always_comb begin
            led_d   = led_q;
            press_d = press_q;
            if (i_Clear) begin
                led_d   = 1'b0;
                press_d = '0;
            end else if (pulse_q) begin
                led_d   = ~led_q;
                press_d = press_q + COUNT_WIDTH'(1);
            end
        end

        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                db_cnt_q <= '0;
                clean_q  <= 1'b0;
                prev_q   <= 1'b0;
                pulse_q  <= 1'b0;
                led_q    <= 1'b0;
                press_q  <= '0;
            end else begin
                sync1_q  <= i_Switch[n];
                sync2_q  <= sync1_q;
                db_cnt_q <= db_cnt_d;
                clean_q  <= clean_d;
                prev_q   <= clean_q;
                pulse_q  <= pulse_d;
                led_q    <= led_d;
                press_q  <= press_d;
            end
        end

        assign o_Switch_Clean[n]                                 = clean_q;
        assign o_Edge_Pulse[n]                                   = pulse_q;
        assign o_LED[n]                                          = led_q;
        assign o_Press_Count[n*COUNT_WIDTH +: COUNT_WIDTH]       = press_q;
    end

endmodule
